mem_wb_stage: RTL and testbench

//  MEM/WB pipeline boundary: registers MEM-stage results and presents them to writeback with a 1-cycle latency.

---
 rtl/npc_pkg.sv | 47 ++++
 rtl/mem_wb_pipe_slot.sv | 19 +
 rtl/mem_wb_stage.sv | 142 ++++++++++++++
 tb/tb_mem_wb_stage.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/npc_pkg.sv
// Shared MEM/WB types: payload struct, bubble constant and skid FSM states.
// Widths come from the sysconfig macros; defaults are supplied here when they are not predefined.
`ifndef XLEN
`define XLEN 64
`endif
`ifndef INST_LEN
`define INST_LEN 32
`endif
`ifndef REG_ADDRWIDTH
`define REG_ADDRWIDTH 5
`endif
`ifndef CSR_REG_ADDRWIDTH
`define CSR_REG_ADDRWIDTH 12
`endif
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

package npc_pkg;

    typedef struct packed {
        logic [`XLEN-1:0]              pc;
        logic [`INST_LEN-1:0]          inst;
        logic [`XLEN-1:0]              mem_data;
        logic [`REG_ADDRWIDTH-1:0]     rd_idx;
        logic [`CSR_REG_ADDRWIDTH-1:0] csr_addr;
        logic [`XLEN-1:0]              csr_data;
        logic                          csr_valid;
    } mem_wb_pkt_t;

    localparam mem_wb_pkt_t MEM_WB_BUBBLE = '{
        pc:        '0,
        inst:      `INST_NOP,
        mem_data:  '0,
        rd_idx:    '0,
        csr_addr:  '0,
        csr_data:  '0,
        csr_valid: 1'b0
    };

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } mem_wb_state_e;

endpackage

// File: rtl/mem_wb_pipe_slot.sv
// One MEM/WB payload register; clear returns it to the bubble so a dead slot never holds stale writes.
module pipe_slot
    import npc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic        clear,
    input  mem_wb_pkt_t d,
    output mem_wb_pkt_t q
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)       q <= MEM_WB_BUBBLE;
        else if (clear) q <= MEM_WB_BUBBLE;
        else if (load)  q <= d;
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM/WB boundary with a 2-entry skid buffer and a registered mem_ready_o.
// Optional retire counter: define MEMWB_RETIRE_CNT_EN to add retire_cnt_o.
module mem_wb_stage
    import npc_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int INST_W = 32,
    parameter int RD_W   = 5,
    parameter int CSR_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic [XLEN-1:0]   pc_i,
    input  logic [INST_W-1:0] inst_i,
    input  logic [XLEN-1:0]   mem_data_i,
    input  logic [RD_W-1:0]   rd_idx_i,
    input  logic [CSR_W-1:0]  csr_addr_i,
    input  logic [XLEN-1:0]   exc_csr_data_i,
    input  logic              exc_csr_valid_i,
    input  logic              wb_ready_i,
    output logic              wb_valid_o,
    output logic [XLEN-1:0]   pc_wb_o,
    output logic [INST_W-1:0] inst_data_wb_o,
    output logic [XLEN-1:0]   mem_data_o,
    output logic [RD_W-1:0]   rd_idx_o,
    output logic [CSR_W-1:0]  csr_addr_o,
    output logic [XLEN-1:0]   exc_csr_data_o,
    output logic              exc_csr_valid_o
`ifdef MEMWB_RETIRE_CNT_EN
    ,
    output logic [63:0]       retire_cnt_o
`endif
);

    mem_wb_state_e state;
    mem_wb_pkt_t   in_pkt, main_d, main_q, skid_q, head;
    logic          accept, drain;
    logic          main_ld, main_clr, skid_ld, skid_clr;

    assign in_pkt = '{pc: pc_i, inst: inst_i, mem_data: mem_data_i, rd_idx: rd_idx_i,
                      csr_addr: csr_addr_i, csr_data: exc_csr_data_i, csr_valid: exc_csr_valid_i};

    assign wb_valid_o = (state != ST_EMPTY);
    assign accept     = mem_valid_i & mem_ready_o;
    assign drain      = wb_valid_o & wb_ready_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ST_EMPTY;
            mem_ready_o <= 1'b1;
        end else if (flush_i) begin
            state       <= ST_EMPTY;
            mem_ready_o <= 1'b1;
        end else begin
            case (state)
                ST_EMPTY: if (accept) state <= ST_ONE;
                ST_ONE: begin
                    if (accept && !drain) begin
                        state       <= ST_FULL;
                        mem_ready_o <= 1'b0;
                    end else if (!accept && drain) begin
                        state <= ST_EMPTY;
                    end
                end
                ST_FULL: begin
                    if (drain) begin
                        state       <= ST_ONE;
                        mem_ready_o <= 1'b1;
                    end
                end
                default: begin
                    state       <= ST_EMPTY;
                    mem_ready_o <= 1'b1;
                end
            endcase
        end
    end

    // Main always holds the head; skid only fills when ONE accepts without draining.
    always_comb begin
        main_ld  = 1'b0;
        main_clr = flush_i;
        skid_ld  = 1'b0;
        skid_clr = flush_i;
        main_d   = in_pkt;
        if (!flush_i) begin
            case (state)
                ST_EMPTY: main_ld = accept;
                ST_ONE: begin
                    main_ld  = accept & drain;
                    skid_ld  = accept & ~drain;
                    main_clr = ~accept & drain;
                end
                ST_FULL: begin
                    main_d   = skid_q;
                    main_ld  = drain;
                    skid_clr = drain;
                end
                default: ;
            endcase
        end
    end

    pipe_slot u_main (
        .clk   (clk),
        .rst   (rst),
        .load  (main_ld),
        .clear (main_clr),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_slot u_skid (
        .clk   (clk),
        .rst   (rst),
        .load  (skid_ld),
        .clear (skid_clr),
        .d     (in_pkt),
        .q     (skid_q)
    );

    assign head            = wb_valid_o ? main_q : MEM_WB_BUBBLE;
    assign pc_wb_o         = head.pc;
    assign inst_data_wb_o  = head.inst;
    assign mem_data_o      = head.mem_data;
    assign rd_idx_o        = head.rd_idx;
    assign csr_addr_o      = head.csr_addr;
    assign exc_csr_data_o  = head.csr_data;
    assign exc_csr_valid_o = head.csr_valid;

`ifdef MEMWB_RETIRE_CNT_EN
    // A drain suppressed by flush never reached writeback, so it is not a retire.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                  retire_cnt_o <= 64'd0;
        else if (drain && !flush_i) retire_cnt_o <= retire_cnt_o + 64'd1;
    end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Scenario bench for mem_wb_stage: directed tasks plus a FIFO scoreboard checking every drain.
`ifndef INST_NOP
`define INST_NOP 32'h0000_0013
`endif

module tb_mem_wb_stage;

    typedef struct packed {
        logic [63:0] pc;
        logic [31:0] inst;
        logic [63:0] data;
        logic [4:0]  rd;
        logic [11:0] caddr;
        logic [63:0] cdata;
        logic        cvld;
    } beat_t;

    logic        clk, rst, flush_i, mem_valid_i, mem_ready_o, wb_ready_i, wb_valid_o;
    logic [63:0] pc_i, mem_data_i, exc_csr_data_i, pc_wb_o, mem_data_o, exc_csr_data_o;
    logic [31:0] inst_i, inst_data_wb_o;
    logic [4:0]  rd_idx_i, rd_idx_o;
    logic [11:0] csr_addr_i, csr_addr_o;
    logic        exc_csr_valid_i, exc_csr_valid_o;
`ifdef MEMWB_RETIRE_CNT_EN
    logic [63:0] retire_cnt_o;
`endif

    int    compared   = 0;
    int    mismatched = 0;
    beat_t sb_q[$];
    beat_t bubble;

    mem_wb_stage dut (
        .clk(clk), .rst(rst), .flush_i(flush_i),
        .mem_valid_i(mem_valid_i), .mem_ready_o(mem_ready_o),
        .pc_i(pc_i), .inst_i(inst_i), .mem_data_i(mem_data_i), .rd_idx_i(rd_idx_i),
        .csr_addr_i(csr_addr_i), .exc_csr_data_i(exc_csr_data_i), .exc_csr_valid_i(exc_csr_valid_i),
        .wb_ready_i(wb_ready_i), .wb_valid_o(wb_valid_o),
        .pc_wb_o(pc_wb_o), .inst_data_wb_o(inst_data_wb_o), .mem_data_o(mem_data_o),
        .rd_idx_o(rd_idx_o), .csr_addr_o(csr_addr_o), .exc_csr_data_o(exc_csr_data_o),
        .exc_csr_valid_o(exc_csr_valid_o)
`ifdef MEMWB_RETIRE_CNT_EN
        , .retire_cnt_o(retire_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic set_beat(input logic [63:0] pc);
        pc_i            = pc;
        inst_i          = pc[31:0] ^ 32'h5a5a_0013;
        mem_data_i      = ~pc;
        rd_idx_i        = pc[6:2];
        csr_addr_i      = pc[13:2];
        exc_csr_data_i  = pc * 3;
        exc_csr_valid_i = pc[2];
    endtask

    // Scoreboard: evaluated just before each rising edge, when inputs and outputs are settled.
    always @(negedge clk) begin
        beat_t obs, exp_b, inb;
        #3;
        obs = '{pc_wb_o, inst_data_wb_o, mem_data_o, rd_idx_o, csr_addr_o, exc_csr_data_o, exc_csr_valid_o};
        inb = '{pc_i, inst_i, mem_data_i, rd_idx_i, csr_addr_i, exc_csr_data_i, exc_csr_valid_i};
        if (!wb_valid_o) begin
            compared++;
            if (obs !== bubble) begin
                mismatched++;
                $display("FAIL sb_bubble: got %h want %h", obs, bubble);
            end
        end
        if (!rst || flush_i) begin
            sb_q.delete();
        end else begin
            if (wb_valid_o && wb_ready_i) begin
                compared++;
                if (sb_q.size() == 0) begin
                    mismatched++;
                    $display("FAIL sb_extra: got beat pc=%h want no beat", pc_wb_o);
                end else begin
                    exp_b = sb_q.pop_front();
                    if (obs !== exp_b) begin
                        mismatched++;
                        $display("FAIL sb_order: got %h want %h", obs, exp_b);
                    end
                end
            end
            if (mem_valid_i && mem_ready_o) sb_q.push_back(inb);
        end
    end

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; flush_i = 1'b0; mem_valid_i = 1'b0; wb_ready_i = 1'b0; set_beat(64'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        compared++;
        if (mem_ready_o !== 1'b1) begin mismatched++; $display("FAIL reset_ready: got %b want 1", mem_ready_o); end
        compared++;
        if (wb_valid_o !== 1'b0) begin mismatched++; $display("FAIL reset_valid: got %b want 0", wb_valid_o); end
        compared++;
        if (pc_wb_o !== 64'h0) begin mismatched++; $display("FAIL reset_pc: got %h want 0", pc_wb_o); end
        compared++;
        if (inst_data_wb_o !== `INST_NOP) begin
            mismatched++; $display("FAIL reset_inst: got %h want %h", inst_data_wb_o, `INST_NOP);
        end
    endtask

    task automatic test_streaming();
        wb_ready_i = 1'b1;
        for (int i = 0; i <= 4; i++) begin
            @(negedge clk);
            if (i > 0) begin
                compared++;
                if (wb_valid_o !== 1'b1 || pc_wb_o !== 64'h8000_0000 + 64'(4 * (i - 1))) begin
                    mismatched++;
                    $display("FAIL stream_pc%0d: got v=%b pc=%h want v=1 pc=%h", i, wb_valid_o, pc_wb_o,
                             64'h8000_0000 + 64'(4 * (i - 1)));
                end
            end
            compared++;
            if (mem_ready_o !== 1'b1) begin mismatched++; $display("FAIL stream_ready%0d: got %b want 1", i, mem_ready_o); end
            mem_valid_i = (i < 4);
            set_beat(64'h8000_0000 + 64'(4 * i));
        end
        @(negedge clk);
        compared++;
        if (wb_valid_o !== 1'b0) begin mismatched++; $display("FAIL stream_end: got v=%b want 0", wb_valid_o); end
    endtask

    task automatic test_stall();
        wb_ready_i = 1'b0;
        mem_valid_i = 1'b1; set_beat(64'h8000_0000);
        @(negedge clk);
        set_beat(64'h8000_0004);
        @(negedge clk);
        compared++;
        if (mem_ready_o !== 1'b0) begin mismatched++; $display("FAIL stall_full: got ready=%b want 0", mem_ready_o); end
        set_beat(64'h8000_0008);
        @(negedge clk);
        compared++;
        if (mem_ready_o !== 1'b0 || pc_wb_o !== 64'h8000_0000) begin
            mismatched++; $display("FAIL stall_hold: got ready=%b pc=%h want 0 80000000", mem_ready_o, pc_wb_o);
        end
        mem_valid_i = 1'b0; wb_ready_i = 1'b1;
        @(negedge clk);
        compared++;
        if (pc_wb_o !== 64'h8000_0004 || mem_ready_o !== 1'b1) begin
            mismatched++; $display("FAIL stall_release: got pc=%h ready=%b want 80000004 1", pc_wb_o, mem_ready_o);
        end
        @(negedge clk);
        compared++;
        if (wb_valid_o !== 1'b0) begin mismatched++; $display("FAIL stall_empty: got v=%b want 0", wb_valid_o); end
    endtask

    task automatic test_flush();
        wb_ready_i = 1'b0;
        mem_valid_i = 1'b1; set_beat(64'h8000_0100);
        @(negedge clk);
        set_beat(64'h8000_0104);
        @(negedge clk);
        flush_i = 1'b1; wb_ready_i = 1'b1; set_beat(64'h8000_0108);
        @(negedge clk);
        flush_i = 1'b0; mem_valid_i = 1'b0;
        compared++;
        if (wb_valid_o !== 1'b0 || pc_wb_o !== 64'h0 || mem_ready_o !== 1'b1) begin
            mismatched++;
            $display("FAIL flush_state: got v=%b pc=%h ready=%b want 0 0 1", wb_valid_o, pc_wb_o, mem_ready_o);
        end
        @(negedge clk);
        compared++;
        if (wb_valid_o !== 1'b0) begin mismatched++; $display("FAIL flush_drop: got v=%b pc=%h want 0", wb_valid_o, pc_wb_o); end
    endtask

    task automatic test_gating();
        wb_ready_i = 1'b0; mem_valid_i = 1'b1;
        set_beat(64'h8000_0200); rd_idx_i = 5'd5; exc_csr_valid_i = 1'b1;
        @(negedge clk);
        mem_valid_i = 1'b0;
        compared++;
        if (rd_idx_o !== 5'd5 || exc_csr_valid_o !== 1'b1) begin
            mismatched++; $display("FAIL gate_live: got rd=%0d cv=%b want 5 1", rd_idx_o, exc_csr_valid_o);
        end
        wb_ready_i = 1'b1;
        @(negedge clk);
        compared++;
        if (rd_idx_o !== 5'd0 || exc_csr_valid_o !== 1'b0 || mem_data_o !== 64'h0) begin
            mismatched++;
            $display("FAIL gate_bubble: got rd=%0d cv=%b data=%h want 0 0 0", rd_idx_o, exc_csr_valid_o, mem_data_o);
        end
    endtask

    task automatic test_retire_cnt();
        rst = 1'b0; mem_valid_i = 1'b0; wb_ready_i = 1'b1; flush_i = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            mem_valid_i = (i < 5) || (i >= 7 && i < 12);
            flush_i     = (i == 6);
            set_beat(64'h9000_0000 + 64'(4 * i));
        end
        @(negedge clk);
        mem_valid_i = 1'b0;
        repeat (2) @(negedge clk);
        compared++;
        if (wb_valid_o !== 1'b0) begin mismatched++; $display("FAIL retire_empty: got v=%b want 0", wb_valid_o); end
`ifdef MEMWB_RETIRE_CNT_EN
        compared++;
        if (retire_cnt_o !== 64'd10) begin mismatched++; $display("FAIL retire_cnt: got %0d want 10", retire_cnt_o); end
`endif
    endtask

    task automatic test_random();
        logic [63:0] seq = 64'h1000;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            mem_valid_i = ($urandom_range(99) < 60);
            wb_ready_i  = ($urandom_range(99) < 55);
            flush_i     = ($urandom_range(199) == 0);
            set_beat(seq);
            seq += 64'd4;
        end
        @(negedge clk);
        mem_valid_i = 1'b0; flush_i = 1'b0; wb_ready_i = 1'b1;
        for (int w = 0; w < 8 && wb_valid_o; w++) @(negedge clk);
        @(negedge clk);
        compared++;
        if (wb_valid_o !== 1'b0 || sb_q.size() != 0) begin
            mismatched++;
            $display("FAIL random_drain: got v=%b left=%0d want 0 0", wb_valid_o, sb_q.size());
        end
    endtask

    initial begin
        bubble = '{64'h0, `INST_NOP, 64'h0, 5'd0, 12'd0, 64'h0, 1'b0};
        rst = 1'b0; flush_i = 1'b0; mem_valid_i = 1'b0; wb_ready_i = 1'b0;
        set_beat(64'h0);
        test_reset();
        test_streaming();
        test_stall();
        test_flush();
        test_gating();
        test_retire_cnt();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
